// File: rtl/periph_regbank_if.sv
// Request/response bus for the peripheral register bank.
// Signals:
//   req    - request valid (master -> slave)
//   we     - 1 = write, 0 = read
//   be     - byte enables, used for writes only
//   addr   - word index
//   wdata  - write data
//   gnt    - request accepted this cycle (slave -> master)
//   rvalid - one-cycle response pulse per accepted request
//   rdata  - read data, 0 when rvalid=0 and for write responses
//   err    - response error, 0 when rvalid=0
interface periph_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/periph_regbank.sv
// Memory-mapped register bank behind the fabric peripheral port.
// Words 0..DEPTH-2 are byte-writable data words; word DEPTH-1 is CTRL
// (bit0 sticky LOCK, bits 15:8 saturating error counter). Every accepted
// request gets exactly one response RD_LAT cycles later, in order.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - periph_regbank_if slave modport (req/we/be/addr/wdata in,
//           gnt/rvalid/rdata/err out)
module periph_regbank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 24,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  periph_regbank_if.slave   bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [ADDR_W:0] CTRL_A = (ADDR_W + 1)'(DEPTH - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH-1];
  logic              lock;
  logic [7:0]        errcnt;

  logic [IDX_W-1:0]  idx;
  logic              is_data;
  logic              is_ctrl;
  logic              is_oor;
  logic              err_now;
  logic [DATA_W-1:0] ctrl_rd;
  logic [DATA_W-1:0] rd_now;

  // Extra leading zero keeps the compare correct for any upper address bits.
  always_comb begin
    idx     = bus.addr[IDX_W-1:0];
    is_data = ({1'b0, bus.addr} < CTRL_A);
    is_ctrl = ({1'b0, bus.addr} == CTRL_A);
    is_oor  = !is_data && !is_ctrl;
    err_now = bus.req && (is_oor || (is_data && bus.we && lock));
    ctrl_rd        = '0;
    ctrl_rd[15:8]  = errcnt;
    ctrl_rd[0]     = lock;
    rd_now = '0;
    if (!bus.we) begin
      if (is_data)      rd_now = mem[idx];
      else if (is_ctrl) rd_now = ctrl_rd;
    end
  end

  assign bus.gnt = bus.req & rst_n;

  // Accept edge: all side effects land here, not at response time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= '0;
      lock   <= 1'b0;
      errcnt <= 8'd0;
    end else if (bus.req) begin
      if (bus.we && is_data && !lock) begin
        for (int b = 0; b < BE_W; b++)
          if (bus.be[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
      if (bus.we && is_ctrl && bus.be[0] && bus.wdata[0]) lock <= 1'b1;
      if (err_now) errcnt <= sat_inc(errcnt);
    end
  end

  // Response pipeline stage 0 .. RD_LAT-1
  logic              vld_p [RD_LAT];
  logic              err_p [RD_LAT];
  logic [DATA_W-1:0] dat_p [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) vld_p[s] <= 1'b0;
    end else begin
      vld_p[0] <= bus.req;
      for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // err/data ride unreset; the output gating by valid hides stale content.
  always_ff @(posedge clk) begin
    err_p[0] <= err_now;
    dat_p[0] <= rd_now;
    for (int s = 1; s < RD_LAT; s++) begin
      err_p[s] <= err_p[s-1];
      dat_p[s] <= dat_p[s-1];
    end
  end

  assign bus.rvalid = vld_p[RD_LAT-1];
  assign bus.err    = vld_p[RD_LAT-1] & err_p[RD_LAT-1];
  assign bus.rdata  = vld_p[RD_LAT-1] ? dat_p[RD_LAT-1] : '0;

endmodule

// File: tb/tb_periph_regbank.sv
module tb_periph_regbank;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 24;
  localparam int RD_LAT = 3;
  localparam logic [23:0] CTRL = 24'(DEPTH - 1);

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  periph_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  periph_regbank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single request; returns gnt at issue, response fields, latency (0 = none)
  // and rvalid one cycle after the response.
  task automatic xact(input logic w, input logic [23:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic g, output logic e,
                      output logic [31:0] r, output int lat, output logic rv_after);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    #1 g = bus.gnt;
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0;
    lat = 1;
    while (!bus.rvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rvalid) lat = 0;
    e = bus.err;
    r = bus.rdata;
    @(negedge clk);
    rv_after = bus.rvalid;
  endtask

  task automatic test_reset();
    logic g, e, rva; logic [31:0] r; int lat;
    rst_n = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'd3; bus.wdata = '0; bus.be = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", bus.gnt); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    bus.req = 1'b0;
    rst_n = 1'b1;
    xact(1'b0, CTRL, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rst_ctrl: got %h/%b want 0/0", r, e); end
    xact(1'b0, 24'd3, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_word3: got %h want 0", r); end
  endtask

  task automatic test_basic();
    logic g, e, rva; logic [31:0] r; int lat;
    xact(1'b1, 24'd3, 32'hDEADBEEF, 4'hF, g, e, r, lat, rva);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", g); end
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, RD_LAT); end
    checks++; if (e !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL wr_resp: got %h/%b want 0/0", r, e); end
    checks++; if (rva !== 1'b0) begin errors++; $display("FAIL wr_pulse: rvalid next cycle %b want 0", rva); end
    xact(1'b0, 24'd3, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, RD_LAT); end
    checks++; if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL rd_word3: got %h/%b want deadbeef/0", r, e); end
  endtask

  task automatic test_byte_en();
    logic g, e, rva; logic [31:0] r; int lat;
    xact(1'b1, 24'd5, 32'h11223344, 4'hF, g, e, r, lat, rva);
    xact(1'b1, 24'd5, 32'hAABBCCDD, 4'b0101, g, e, r, lat, rva);
    xact(1'b0, 24'd5, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en: got %h want 11bb33dd", r); end
    xact(1'b1, 24'd5, 32'hFFFFFFFF, 4'h0, g, e, r, lat, rva);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL be0_err: got %b want 0", e); end
    xact(1'b0, 24'd5, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL be0_nochange: got %h want 11bb33dd", r); end
  endtask

  task automatic test_back_to_back();
    logic g, e, rva; logic [31:0] r; int lat;
    logic exp_v; logic [31:0] exp_d;
    for (int i = 0; i < 4; i++)
      xact(1'b1, 24'(i), 32'h0A0A0000 + 32'(i), 4'hF, g, e, r, lat, rva);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_v = (c >= RD_LAT) && (c < RD_LAT + 4);
      exp_d = exp_v ? 32'h0A0A0000 + 32'(c - RD_LAT) : 32'h0;
      checks++;
      if (bus.rvalid !== exp_v || bus.rdata !== exp_d) begin
        errors++;
        $display("FAIL b2b_cyc%0d: got v=%b d=%h want v=%b d=%h", c, bus.rvalid, bus.rdata, exp_v, exp_d);
      end
      if (c < 4) begin bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'(c); end
      else bus.req = 1'b0;
    end
  endtask

  task automatic test_out_of_range();
    logic g, e, rva; logic [31:0] r; int lat;
    xact(1'b0, 24'(DEPTH), 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL oor_depth: got %h/%b want 0/1", r, e); end
    xact(1'b0, 24'h100000, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL oor_high: got %h/%b want 0/1", r, e); end
    xact(1'b0, CTRL, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0200 || e !== 1'b0) begin errors++; $display("FAIL oor_errcnt: got %h/%b want 00000200/0", r, e); end
  endtask

  task automatic test_lock();
    logic g, e, rva; logic [31:0] r; int lat;
    xact(1'b1, CTRL, 32'h1, 4'h1, g, e, r, lat, rva);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lock_set_err: got %b want 0", e); end
    xact(1'b1, 24'd0, 32'h12345678, 4'hF, g, e, r, lat, rva);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL locked_wr_err: got %b want 1", e); end
    xact(1'b0, 24'd0, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0A0A0000 || e !== 1'b0) begin errors++; $display("FAIL locked_word0: got %h/%b want 0a0a0000/0", r, e); end
    xact(1'b1, CTRL, 32'h0, 4'hF, g, e, r, lat, rva);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ctrl_wr_locked_err: got %b want 0", e); end
    xact(1'b1, 24'd0, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL locked_be0_err: got %b want 1", e); end
    xact(1'b0, CTRL, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0401) begin errors++; $display("FAIL lock_sticky: got %h want 00000401", r); end
  endtask

  task automatic test_saturate();
    logic g, e, rva; logic [31:0] r; int lat;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'hFFFFFF;
    repeat (300) @(negedge clk);
    bus.req = 1'b0;
    repeat (RD_LAT + 2) @(negedge clk);
    xact(1'b0, CTRL, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'hFF01) begin errors++; $display("FAIL errcnt_sat: got %h want 0000ff01", r); end
  endtask

  task automatic test_reset_midflight();
    logic g, e, rva; logic [31:0] r; int lat;
    logic seen;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'd3;
    @(negedge clk);
    bus.addr = 24'd5;
    @(negedge clk);
    bus.req = 1'b0;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1 if (bus.rvalid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL inflight_dropped: rvalid seen %b want 0", seen); end
    rst_n = 1'b1;
    xact(1'b0, CTRL, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL post_rst_latency: got %0d want %0d", lat, RD_LAT); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL post_rst_ctrl: got %h want 0", r); end
    xact(1'b0, 24'd3, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL post_rst_word3: got %h want 0", r); end
    xact(1'b0, 24'd5, 32'h0, 4'h0, g, e, r, lat, rva);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL post_rst_word5: got %h want 0", r); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_basic();
    test_byte_en();
    test_back_to_back();
    test_out_of_range();
    test_lock();
    test_saturate();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
